// File: rtl/normshift_pipe.sv
// Pipelined logical left/right significand shifter with valid/ready handshake, flush and tag.
// Define NORMSHIFT_STICKY_EN to build the right-shift sticky accumulation; otherwise Sticky is 0.
module normshift_pipe #(
    parameter int WIDTH    = 64,
    parameter int LOGWIDTH = 7,
    parameter int STAGES   = 2,
    parameter int TAGW     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Flush,
    input  logic                InValid,
    output logic                InReady,
    input  logic                ShiftRight,
    input  logic [LOGWIDTH-1:0] ShiftAmt,
    input  logic [WIDTH-1:0]    ShiftIn,
    input  logic [TAGW-1:0]     TagIn,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [WIDTH-1:0]    Shifted,
    output logic                Sticky,
    output logic [TAGW-1:0]     TagOut
);

    // Shift-amount bit b is applied by stage (b*STAGES)/LOGWIDTH: contiguous, non-empty groups.
    function automatic logic [LOGWIDTH-1:0] group_mask(input int s);
        logic [LOGWIDTH-1:0] m;
        m = '0;
        for (int b = 0; b < LOGWIDTH; b++) begin
            if ((b * STAGES) / LOGWIDTH == s) m[b] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] x,
                                                     input logic [LOGWIDTH-1:0] amt,
                                                     input logic right);
        return right ? (x >> amt) : (x << amt);
    endfunction

    logic [STAGES-1:0]   valid_q;
    logic [STAGES-1:0]   load;
    logic [STAGES-1:0]   right_q;
    logic [WIDTH-1:0]    data_q [STAGES];
    logic [WIDTH-1:0]    data_d [STAGES];
    logic [LOGWIDTH-1:0] amt_q  [STAGES];
    logic [TAGW-1:0]     tag_q  [STAGES];
    logic                accept;

    // A stage loads when empty or when its successor loads; the chain starts at OutReady.
    always_comb begin
        logic chain;
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        chain = !valid_q[STAGES-1] | OutReady;
        load  = '0;
        load[STAGES-1] = chain;
        for (int s = STAGES - 2; s >= 0; s--) begin
            chain   = !valid_q[s] | chain;
            load[s] = chain;
        end
    end

    assign accept  = InValid & !Flush & load[0];
    assign InReady = reset | (!Flush & load[0]);

    always_comb begin
        data_d[0] = stage_shift(ShiftIn, ShiftAmt & group_mask(0), ShiftRight);
        for (int s = 1; s < STAGES; s++) begin
            data_d[s] = stage_shift(data_q[s-1], amt_q[s-1] & group_mask(s), right_q[s-1]);
        end
    end

    // NOTE: state uses non-blocking assignments so every stage samples its predecessor's old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: payload registers are reset too because they drive the block outputs directly.
            valid_q <= '0;
            right_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                amt_q[s]  <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            if (Flush) begin
                valid_q <= '0;
            end else begin
                if (load[0]) valid_q[0] <= InValid;
                for (int s = 1; s < STAGES; s++) begin
                    if (load[s]) valid_q[s] <= valid_q[s-1];
                end
            end
            if (accept) begin
                data_q[0]  <= data_d[0];
                amt_q[0]   <= ShiftAmt;
                right_q[0] <= ShiftRight;
                tag_q[0]   <= TagIn;
            end
            // Payload moves only with a real operation, so held outputs never glitch on bubbles.
            for (int s = 1; s < STAGES; s++) begin
                if (load[s] && valid_q[s-1]) begin
                    data_q[s]  <= data_d[s];
                    amt_q[s]   <= amt_q[s-1];
                    right_q[s] <= right_q[s-1];
                    tag_q[s]   <= tag_q[s-1];
                end
            end
        end
    end

`ifdef NORMSHIFT_STICKY_EN
    // Bits dropped by one stage; an amount >= WIDTH makes the mask all ones.
    function automatic logic stage_lost(input logic [WIDTH-1:0] x,
                                        input logic [LOGWIDTH-1:0] amt,
                                        input logic right);
        return right & (|(x & ~({WIDTH{1'b1}} << amt)));
    endfunction

    logic [STAGES-1:0] sticky_q;
    logic [STAGES-1:0] sticky_d;

    always_comb begin
        sticky_d    = '0;
        sticky_d[0] = stage_lost(ShiftIn, ShiftAmt & group_mask(0), ShiftRight);
        for (int s = 1; s < STAGES; s++) begin
            sticky_d[s] = sticky_q[s-1] |
                          stage_lost(data_q[s-1], amt_q[s-1] & group_mask(s), right_q[s-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= '0;
        end else begin
            if (accept) sticky_q[0] <= sticky_d[0];
            for (int s = 1; s < STAGES; s++) begin
                if (load[s] && valid_q[s-1]) sticky_q[s] <= sticky_d[s];
            end
        end
    end

    assign Sticky = sticky_q[STAGES-1];
`else
    assign Sticky = 1'b0;
`endif

    assign OutValid = valid_q[STAGES-1];
    assign Shifted  = data_q[STAGES-1];
    assign TagOut   = tag_q[STAGES-1];

endmodule

// File: tb/tb_normshift_pipe.sv
// Scoreboard bench for normshift_pipe (WIDTH=16, LOGWIDTH=5, STAGES=2): directed vectors,
// expected results queued at acceptance and compared by an independent output monitor.
module tb_normshift_pipe;

    localparam int WIDTH    = 16;
    localparam int LOGWIDTH = 5;
    localparam int STAGES   = 2;
    localparam int TAGW     = 4;
`ifdef NORMSHIFT_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sticky;
        logic [TAGW-1:0]  tag;
    } exp_t;

    logic                clk;
    logic                reset;
    logic                Flush;
    logic                InValid;
    logic                InReady;
    logic                ShiftRight;
    logic [LOGWIDTH-1:0] ShiftAmt;
    logic [WIDTH-1:0]    ShiftIn;
    logic [TAGW-1:0]     TagIn;
    logic                OutValid;
    logic                OutReady;
    logic [WIDTH-1:0]    Shifted;
    logic                Sticky;
    logic [TAGW-1:0]     TagOut;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    normshift_pipe #(
        .WIDTH(WIDTH), .LOGWIDTH(LOGWIDTH), .STAGES(STAGES), .TAGW(TAGW)
    ) dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .ShiftRight(ShiftRight), .ShiftAmt(ShiftAmt), .ShiftIn(ShiftIn), .TagIn(TagIn),
        .OutValid(OutValid), .OutReady(OutReady),
        .Shifted(Shifted), .Sticky(Sticky), .TagOut(TagOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offers one operation (driven just after a rising edge) until accepted; pushes its expectation.
    task automatic issue(input logic right, input logic [LOGWIDTH-1:0] amt,
                         input logic [WIDTH-1:0] din, input logic [TAGW-1:0] tag,
                         input logic [WIDTH-1:0] exp_d, input logic exp_s, input bit push);
        bit taken;
        taken      = 1'b0;
        ShiftRight = right;
        ShiftAmt   = amt;
        ShiftIn    = din;
        TagIn      = tag;
        InValid    = 1'b1;
        for (int i = 0; i < 20 && !taken; i++) begin
            @(negedge clk);
            taken = InReady;
            @(posedge clk);
            #1;
        end
        check("accept", {31'b0, taken}, 32'd1);
        if (taken && push) sb.push_back('{exp_d, exp_s & STICKY_EN, tag});
        InValid = 1'b0;
    endtask

    task automatic idle(input int n);
        InValid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && OutValid && OutReady) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {31'b0, OutValid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("shifted", {16'b0, Shifted}, {16'b0, mon_e.data});
                check("sticky", {31'b0, Sticky}, {31'b0, mon_e.sticky});
                check("tag", {28'b0, TagOut}, {28'b0, mon_e.tag});
            end
        end
    end

    initial begin
        reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        ShiftRight = 1'b0; ShiftAmt = '0; ShiftIn = '0; TagIn = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_inready", {31'b0, InReady}, 32'd1);
        check("reset_outvalid", {31'b0, OutValid}, 32'd0);
        check("reset_shifted", {16'b0, Shifted}, 32'd0);
        check("reset_sticky", {31'b0, Sticky}, 32'd0);
        check("reset_tag", {28'b0, TagOut}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Left shift with explicit two-cycle latency check.
        issue(1'b0, 5'd15, 16'h0001, 4'h5, 16'h8000, 1'b0, 1'b1);
        @(negedge clk);
        check("latency_early", {31'b0, OutValid}, 32'd0);
        @(negedge clk);
        check("latency_out", {31'b0, OutValid}, 32'd1);
        @(posedge clk); #1;
        idle(2);

        // Back-to-back directed vectors, including saturation boundaries.
        issue(1'b1, 5'd4,  16'h00FF, 4'h2, 16'h000F, 1'b1, 1'b1);
        issue(1'b1, 5'd8,  16'h0F00, 4'h3, 16'h000F, 1'b0, 1'b1);
        issue(1'b1, 5'd20, 16'h8001, 4'h4, 16'h0000, 1'b1, 1'b1);
        issue(1'b0, 5'd20, 16'h8001, 4'h6, 16'h0000, 1'b0, 1'b1);
        issue(1'b0, 5'd4,  16'hABCD, 4'h7, 16'hBCD0, 1'b0, 1'b1);
        issue(1'b1, 5'd0,  16'hABCD, 4'h8, 16'hABCD, 1'b0, 1'b1);
        issue(1'b1, 5'd16, 16'hFFFF, 4'h9, 16'h0000, 1'b1, 1'b1);
        issue(1'b0, 5'd31, 16'h1234, 4'hA, 16'h0000, 1'b0, 1'b1);
        issue(1'b1, 5'd15, 16'hC000, 4'hB, 16'h0001, 1'b1, 1'b1);
        idle(5);
        check("drained_1", sb.size(), 32'd0);

        // Backpressure: two ops fill the pipe, the third waits.
        OutReady = 1'b0;
        issue(1'b0, 5'd1, 16'h0003, 4'h1, 16'h0006, 1'b0, 1'b1);
        issue(1'b1, 5'd4, 16'h00F0, 4'h2, 16'h000F, 1'b0, 1'b1);
        ShiftRight = 1'b1; ShiftAmt = 5'd1; ShiftIn = 16'h0011; TagIn = 4'h3; InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_inready", {31'b0, InReady}, 32'd0);
            check("hold_valid", {31'b0, OutValid}, 32'd1);
            check("hold_tag", {28'b0, TagOut}, 32'h1);
            check("hold_shifted", {16'b0, Shifted}, 32'h0006);
            @(posedge clk); #1;
        end
        OutReady = 1'b1;
        @(negedge clk);
        check("accept_when_full", {31'b0, InReady}, 32'd1);
        check("nobubble_0", {31'b0, OutValid}, 32'd1);
        @(posedge clk);
        sb.push_back('{16'h0008, STICKY_EN, 4'h3});
        #1 InValid = 1'b0;
        @(negedge clk);
        check("nobubble_1", {31'b0, OutValid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("nobubble_2", {31'b0, OutValid}, 32'd1);
        @(posedge clk); #1;
        idle(3);
        check("drained_2", sb.size(), 32'd0);

        // Flush with two ops in flight and a simultaneous offer: nothing may emerge.
        OutReady = 1'b0;
        issue(1'b0, 5'd2, 16'h0101, 4'h6, 16'h0404, 1'b0, 1'b0);
        issue(1'b1, 5'd3, 16'h0808, 4'h7, 16'h0101, 1'b0, 1'b0);
        ShiftRight = 1'b0; ShiftAmt = 5'd1; ShiftIn = 16'h0001; TagIn = 4'h8; InValid = 1'b1;
        Flush = 1'b1;
        @(negedge clk);
        check("flush_inready", {31'b0, InReady}, 32'd0);
        @(posedge clk);
        #1 Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        @(negedge clk);
        check("flush_outvalid", {31'b0, OutValid}, 32'd0);
        @(posedge clk); #1;
        // Flush on an empty pipe still refuses the offer.
        TagIn = 4'h9; InValid = 1'b1; Flush = 1'b1;
        @(negedge clk);
        check("flush_empty_inready", {31'b0, InReady}, 32'd0);
        @(posedge clk);
        #1 Flush = 1'b0; InValid = 1'b0;
        idle(5);

        // Reset mid-stream drops the in-flight op.
        issue(1'b1, 5'd1, 16'h0003, 4'hA, 16'h0001, 1'b1, 1'b0);
        reset = 1'b1;
        TagIn = 4'hC; InValid = 1'b1;
        @(negedge clk);
        check("inready_in_reset", {31'b0, InReady}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("midreset_outvalid", {31'b0, OutValid}, 32'd0);
        check("midreset_shifted", {16'b0, Shifted}, 32'd0);
        check("midreset_sticky", {31'b0, Sticky}, 32'd0);
        check("midreset_tag", {28'b0, TagOut}, 32'd0);
        check("midreset_inready", {31'b0, InReady}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0; InValid = 1'b0;
        issue(1'b1, 5'd0, 16'h1234, 4'hB, 16'h1234, 1'b0, 1'b1);
        @(negedge clk);
        check("fresh_latency_early", {31'b0, OutValid}, 32'd0);
        @(negedge clk);
        check("fresh_latency_out", {31'b0, OutValid}, 32'd1);
        @(posedge clk); #1;
        idle(4);
        check("drained_3", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/normshift_pipe.md
Name: normshift_pipe

Overview:
- Pipelined, parametrised successor to the FPU combinational normalisation shifter.
- Performs a logical left or right shift of a WIDTH-bit significand over STAGES register stages, with a valid/ready handshake, a flush input and a per-operation tag.
- In right-shift mode it collects the shifted-out bits into a sticky bit for rounding.
- Sits between the FMA/divsqrt/convert datapaths and the rounding unit in the postprocessor when the combinational shift limits cycle time.

Parameters:
- WIDTH, 64, data width of ShiftIn and Shifted.
- LOGWIDTH, 7, width of ShiftAmt. Must satisfy 2^LOGWIDTH >= WIDTH.
- STAGES, 2, pipeline register stages, legal range 1..LOGWIDTH. Latency equals STAGES.
- TAGW, 4, width of the pass-through operation tag.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- Flush  input  1  discard all in-flight operations
- InValid  input  1  an operation is offered
- InReady  output  1  block accepts the offered operation this cycle
- ShiftRight  input  1  0 = left shift, 1 = right shift
- ShiftAmt  input  LOGWIDTH  shift distance
- ShiftIn  input  WIDTH  operand
- TagIn  input  TAGW  operation tag
- OutValid  output  1  result available
- OutReady  input  1  consumer takes the result this cycle
- Shifted  output  WIDTH  shifted result
- Sticky  output  1  OR of all bits shifted out (right mode only)
- TagOut  output  TAGW  tag of the presented result

Behaviour:
- Clock and reset: single clock. Reset is synchronous, active-high. Reset clears every stage valid bit.
  - OutValid = 0, Shifted = 0, Sticky = 0, TagOut = 0 one edge after reset is sampled high.
  - Reset mid-operation drops all in-flight work.
  - InReady = 1 during and after reset.
- Transfers: an input transfer occurs on a rising edge with InValid & InReady. An output transfer occurs with OutValid & OutReady.
- Shift decomposition: shift-amount bits are partitioned into STAGES contiguous groups, each stage applying its group. The partition is implementation choice. The final result must bit-match the combinational model:
  - Left: Shifted = ShiftIn << ShiftAmt, truncated to WIDTH.
  - Right: Shifted = ShiftIn >> ShiftAmt, zero fill.
  - Sticky = |(ShiftIn & ((1<<ShiftAmt)-1)) in right mode; 0 in left mode.
- Saturation: ShiftAmt >= WIDTH gives Shifted = 0. Sticky = |ShiftIn in right mode.
- Sticky accumulation: each stage ORs its shifted-out bits into a carried sticky bit, so no stage loses dropped bits.
- Latency and throughput: exactly STAGES cycles from accepted input to OutValid, with no backpressure. One result per cycle sustained.
- Stage advance: stage i register loads when it is empty or stage i+1 loads (for the last stage, when OutReady).
  - InReady = !valid[0] | stage 0 advances. It is combinational from OutReady through the stage chain. No combinational path from InValid to InReady.
- Backpressure: while OutValid & !OutReady, Shifted, Sticky and TagOut hold stable.
  - Up to STAGES operations are buffered.
  - Order is preserved; no drop, no duplication.
- Flush: on a rising edge with Flush = 1, all valid bits clear, and any simultaneous input is not accepted.
  - InReady is forced to 0 while Flush = 1.
  - OutValid = 0 on the following cycle.
  - Data registers need not clear.
- Simultaneous accept and release: when full and OutReady = 1, a new input is accepted in the same cycle. The pipeline shifts without a bubble.
- Output data registers update only on stage load, which keeps verification waveforms stable.

Optional Feature:
- Macro: NORMSHIFT_STICKY_EN.
- Defined: sticky logic is built as described above. Right-shift Sticky is exact.
- Undefined: Sticky is tied to 0 and no sticky registers exist. Shift results, latency and handshake are unchanged. Clients must then compute sticky externally.

Test Plan (WIDTH=16, LOGWIDTH=5, STAGES=2, OutReady=1 unless stated):
- Left shift: ShiftIn=0x0001, ShiftAmt=15 -> 2 cycles later OutValid=1, Shifted=0x8000, Sticky=0, TagOut=TagIn.
- Right shift, nonzero sticky: ShiftIn=0x00FF, ShiftAmt=4 -> Shifted=0x000F, Sticky=1.
- Right shift, zero sticky: ShiftIn=0x0F00, ShiftAmt=8 -> Shifted=0x000F, Sticky=0.
- Saturation: right, ShiftIn=0x8001, ShiftAmt=20 -> Shifted=0x0000, Sticky=1. Left, same operands -> Shifted=0x0000, Sticky=0.
- Backpressure: tags 1,2,3 offered back-to-back with OutReady=0 -> only tags 1,2 accepted, then InReady=0 and output holds tag 1 stable. After OutReady=1, results emerge in order 1,2,3 with no bubble.
- Flush and reset: Flush pulsed with 2 ops in flight -> OutValid=0 the next cycle and neither result ever appears. Reset asserted mid-stream -> all outputs 0 the next cycle, InReady=1, and a fresh op completes in 2 cycles.
